// File: rtl/cla_pipe_adder_pkg.sv
// Shared arithmetic helpers for the pipelined lookahead adder: default group
// size, a ceil-log2 helper and the per-stage register layout.
package cla_pipe_adder_pkg;

    localparam int DEF_GRP = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Sum bits held by stage k: every group resolved so far.
    function automatic int sum_w(input int grp, input int k);
        return (k + 1) * grp;
    endfunction

    // Operand bits still to be consumed after stage k (per operand).
    function automatic int opnd_w(input int width, input int grp, input int k);
        return width - (k + 1) * grp;
    endfunction

    // Carry field per stage is always a single bit.
    function automatic int carry_w(input int k);
        return (k >= 0) ? 1 : 1;
    endfunction

    // Legal configuration: 1..8 bit groups that tile the operand exactly.
    function automatic bit cfg_ok(input int width, input int grp);
        return (grp >= 1) && (grp <= 8) && (width >= grp) && ((width % grp) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Streaming operand/result bus for the pipelined adder. The master side
// supplies operands and result back-pressure; the slave side is the adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/cla_pipe_adder_group.sv
// One GRP-bit carry-lookahead group: every internal carry is formed directly
// from the group's generate/propagate terms and the incoming carry.
module cla_pipe_adder_group #(
    parameter int GRP = 4
) (
    input  logic [GRP-1:0] i_a,
    input  logic [GRP-1:0] i_b,
    input  logic           i_cin,
    output logic [GRP-1:0] o_sum,
    output logic           o_cout
);

    logic [GRP-1:0] w_p;
    logic [GRP-1:0] w_g;
    logic [GRP:0]   w_c;

    genvar gi;
    generate
        for (gi = 0; gi < GRP; gi++) begin : gen_pg
            assign w_p[gi]   = i_a[gi] | i_b[gi];
            assign w_g[gi]   = i_a[gi] & i_b[gi];
            assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        end
    endgenerate

    // Flat lookahead: c[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & cin)
    always_comb begin
        logic v_carry;
        logic v_term;
        v_carry = 1'b0;
        v_term  = 1'b0;
        w_c     = '0;
        w_c[0]  = i_cin;
        for (int i = 1; i <= GRP; i++) begin
            v_carry = i_cin;
            for (int j = 0; j < i; j++) begin
                v_carry = v_carry & w_p[j];
            end
            for (int j = 0; j < i; j++) begin
                v_term = w_g[j];
                for (int m = j + 1; m < i; m++) begin
                    v_term = v_term & w_p[m];
                end
                v_carry = v_carry | v_term;
            end
            w_c[i] = v_carry;
        end
    end

    assign o_cout = w_c[GRP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. One GRP-bit group is resolved
// per stage; the carry ripples between stages through registers, and a
// combinational ready chain lets beats compact behind a stalled output.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = DEF_GRP
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);

    localparam int NSTG = WIDTH / GRP;

    // Reject illegal geometry before anything else elaborates.
    if (!cfg_ok(WIDTH, GRP)) begin : gen_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of GRP and GRP must be 1..8");
    end
    if ($bits(bus.in_a) != WIDTH) begin : gen_bus_err
        $error("cla_pipe_adder: interface WIDTH does not match adder WIDTH");
    end

    // Per-stage valid bits and advance (may-load) enables.
    logic [NSTG-1:0] w_v;
    logic [NSTG-1:0] w_adv;

    // Ready chain: a stage may load when it is empty or its successor loads.
    always_comb begin
        logic v_adv;
        v_adv = ~w_v[NSTG-1] | bus.out_ready;
        w_adv = '0;
        w_adv[NSTG-1] = v_adv;
        for (int k = NSTG - 2; k >= 0; k--) begin
            v_adv    = ~w_v[k] | v_adv;
            w_adv[k] = v_adv;
        end
    end

    assign bus.in_ready = w_adv[0];

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : gen_stg
            localparam int IW = WIDTH - gi * GRP;   // operand bits arriving here
            localparam int SW = sum_w(GRP, gi);     // sum bits held after here
            localparam int OW = opnd_w(WIDTH, GRP, gi);

            logic [IW-1:0]  w_a_in;
            logic [IW-1:0]  w_b_in;
            logic           w_c_in;
            logic           w_v_in;
            logic [GRP-1:0] w_s;
            logic           w_co;
            logic [SW-1:0]  w_sum_next;

            logic [SW-1:0]  r_sum;
            logic           r_c;
            logic           r_v;

            if (gi == 0) begin : gen_src_in
                // Subtraction folds into the adder: invert B and the carry-in.
                assign w_a_in     = bus.in_a;
                assign w_b_in     = bus.in_b ^ {WIDTH{bus.in_sub}};
                assign w_c_in     = bus.in_sub ^ bus.in_cin;
                assign w_v_in     = bus.in_valid;
                assign w_sum_next = w_s;
            end else begin : gen_src_stg
                assign w_a_in     = gen_stg[gi-1].gen_fwd.r_a;
                assign w_b_in     = gen_stg[gi-1].gen_fwd.r_b;
                assign w_c_in     = gen_stg[gi-1].r_c;
                assign w_v_in     = gen_stg[gi-1].r_v;
                assign w_sum_next = {w_s, gen_stg[gi-1].r_sum};
            end

            cla_pipe_adder_group #(
                .GRP (GRP)
            ) u_grp (
                .i_a    (w_a_in[GRP-1:0]),
                .i_b    (w_b_in[GRP-1:0]),
                .i_cin  (w_c_in),
                .o_sum  (w_s),
                .o_cout (w_co)
            );

            assign w_v[gi] = r_v;

            // Stage register: valid follows upstream on advance; data only
            // loads with a real beat so it holds across bubbles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_sum <= '0;
                end else if (w_adv[gi]) begin
                    r_v <= w_v_in;
                    if (w_v_in) begin
                        r_c   <= w_co;
                        r_sum <= w_sum_next;
                    end
                end
            end

            if (gi < NSTG - 1) begin : gen_fwd
                logic [OW-1:0] r_a;
                logic [OW-1:0] r_b;

                // Carry the not-yet-consumed operand bits to the next stage.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv[gi] && w_v_in) begin
                        r_a <= w_a_in[IW-1:GRP];
                        r_b <= w_b_in[IW-1:GRP];
                    end
                end
            end else begin : gen_last
                logic r_ovf;
                logic r_zero;

                // Flags for the finished word; same-sign operands giving a
                // differently-signed sum is equivalent to c_in(MSB) ^ c_out.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                    end else if (w_adv[gi] && w_v_in) begin
                        r_ovf  <= (w_a_in[IW-1] ~^ w_b_in[IW-1]) & (w_s[GRP-1] ^ w_a_in[IW-1]);
                        r_zero <= ~|w_sum_next;
                    end
                end

                assign bus.out_valid = r_v;
                assign bus.out_sum   = r_sum;
                assign bus.out_cout  = r_c;
                assign bus.out_ovf   = r_ovf;
                assign bus.out_zero  = r_zero;
            end
        end
    endgenerate

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for the pipelined adder: expected results are queued as
// beats are accepted and compared in order as results leave the pipe.
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NS = W / G;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH (W),
        .GRP   (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    bit   chk_lat    = 1'b0;
    bit   last_acc   = 1'b0;
    bit   prev_stall = 1'b0;
    res_t prev_out;
    sb_t  sb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Golden model: wide addition; overflow from carry into vs out of MSB.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        res_t         r;
        bb     = sub ? ~b : b;
        c0     = sub ? ~cin : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        low    = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        r.zero = (full[W-1:0] == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, evaluate 1 ns later.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic ordy, input res_t e);
        sb_t  ent;
        res_t got;
        bit   stall;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        bus.in_cin    = cin;
        bus.out_ready = ordy;
        #1;
        check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, (sb.size() < NS) || ordy});
        got   = {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
        stall = bus.out_valid && !ordy;
        if (stall && prev_stall) check_val("stall_hold", 32'(got), 32'(prev_out));
        prev_stall = stall;
        prev_out   = got;
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                check_val("extra_beat", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                ent = sb.pop_front();
                check_val("sum",  32'(got.sum),  32'(ent.r.sum));
                check_val("cout", 32'(got.cout), 32'(ent.r.cout));
                check_val("ovf",  32'(got.ovf),  32'(ent.r.ovf));
                check_val("zero", 32'(got.zero), 32'(ent.r.zero));
                if (chk_lat) check_val("latency", 32'(cyc - ent.cyc), 32'(NS));
            end
        end
        last_acc = v && bus.in_ready;
        if (last_acc) begin
            ent.r   = e;
            ent.cyc = cyc;
            sb.push_back(ent);
        end
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb.size() != 0; i++) idle(1'b1);
        check_val("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic direct(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input res_t e);
        step(1'b1, a, b, sub, cin, 1'b1, e);
        check_val("direct_acc", {31'd0, last_acc}, 32'd1);
        drain(12);
        $display("direct a=%04h b=%04h sub=%0b cin=%0b exp=%04h/%0b%0b%0b",
                 a, b, sub, cin, e.sum, e.cout, e.ovf, e.zero);
    endtask

    initial begin
        int sent;
        int guard;
        logic v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        logic c;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_out_sum",   32'(bus.out_sum), 32'd0);
        check_val("rst_flags",     {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed arithmetic with latency checks
        chk_lat = 1'b1;
        direct(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
        direct(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
        direct(16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
        direct(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
        direct(16'h0010, 16'h0003, 1'b1, 1'b1, '{16'h000C, 1'b1, 1'b0, 1'b0});
        chk_lat = 1'b0;

        // Back-pressure stream: 8 beats, output stalled for cycles 4..9
        sent = 0;
        for (int k = 0; k < 30; k++) begin
            logic ordy;
            ordy = !(k >= 4 && k <= 9);
            if (sent < 8) begin
                a = W'(sent);
                b = W'(16'h0100 * sent);
                step(1'b1, a, b, 1'b0, 1'b0, ordy, model(a, b, 1'b0, 1'b0));
                if (last_acc) begin
                    $display("bp beat %0d accepted at cycle %0d", sent, k);
                    sent++;
                end
            end else begin
                idle(ordy);
            end
        end
        check_val("bp_sent", 32'(sent), 32'd8);
        drain(12);

        // Random stream against the golden model
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            step(v, a, b, s, c, ($urandom_range(0, 3) != 0), model(a, b, s, c));
            if (last_acc) sent++;
            guard++;
        end
        check_val("rand_sent", 32'(sent), 32'd10000);
        drain(20);
        $display("random stream done: %0d beats in %0d cycles", sent, guard);

        // Reset with three beats in flight and the output stalled
        step(1'b1, 16'h8001, 16'h8000, 1'b0, 1'b0, 1'b0, model(16'h8001, 16'h8000, 1'b0, 1'b0));
        step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, model(16'h0001, 16'h0002, 1'b0, 1'b0));
        step(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, model(16'h0003, 16'h0004, 1'b0, 1'b0));
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        check_val("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("pre_rst_sum",   32'(bus.out_sum), 32'h0001);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("mid_rst_sum",   32'(bus.out_sum), 32'd0);
        check_val("mid_rst_flags", {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk_lat = 1'b1;
        direct(16'h1234, 16'h0FED, 1'b0, 1'b1, model(16'h1234, 16'h0FED, 1'b0, 1'b1));
        chk_lat = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the fixed 4-bit lookahead adder.
- WIDTH-bit operands are split into GRP-bit lookahead groups; one group is resolved per pipeline stage, with carry rippled stage-to-stage through registers.
- Adds subtract mode, carry/borrow-in, signed overflow and zero flags, and a valid/ready streaming handshake with full back-pressure.
- Used by game-logic datapaths (score, coordinates, timers) that need wide arithmetic at full clock rate.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GRP.
- GRP, 4, bits per lookahead group (1..8); NSTG = WIDTH/GRP pipeline stages.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A, unsigned or two's complement.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out of MSB; in sub mode 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Arithmetic: B' = in_sub ? ~in_b : in_b; c0 = in_sub ? ~in_cin : in_cin; result = A + B' + c0, modulo 2^WIDTH.
- Group k (bits k*GRP .. k*GRP+GRP−1): Pi = Ai|B'i, Gi = Ai&B'i; full lookahead inside the group; Si = Ai^B'i^Ci.
- out_ovf = carry into MSB XOR carry out of MSB. out_cout = carry out of MSB.
- Pipeline: stages 0..NSTG−1. Stage k computes group k from its registered carry and registers:
  - sum bits 0..k*GRP+GRP−1;
  - the unconsumed upper operand bits;
  - the carry out;
  - a valid bit.
- The stage NSTG−1 register drives the outputs directly; outputs are fully registered.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTG−1 (visible in the cycle following edge t+NSTG−1). Throughput is 1 beat/cycle.
- Handshake, per stage k:
  - advance_k = ~valid_k | advance_{k+1}; the last stage uses advance = ~out_valid | out_ready.
  - in_ready = advance_0; this is the combinational ready chain, with no bubbles required.
  - A beat transfers on in_valid & in_ready, and on out_valid & out_ready.
- Stall: when out_valid=1 and out_ready=0, all outputs hold stable; full stages hold their contents.
- Empty stages still accept beats, so in-flight beats compact behind the stalled head. in_ready falls only once all NSTG stages are full.
- in_valid=0 while in_ready=1: a bubble enters; the valid bit of stage 0 clears.
- Simultaneous accept at input and output on a full pipe is legal; the pipe stays full and no beat is lost.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Reset (asynchronous, any time, including mid-stream):
  - all valid bits clear immediately; out_valid=0;
  - out_sum=0, out_cout=0, out_ovf=0, out_zero=0;
  - in_ready=1 after reset release;
  - in-flight beats are discarded.
- out_zero, out_ovf and out_cout are meaningful only while out_valid=1. They are held at their last value otherwise.
- Non-multiple WIDTH or GRP outside 1..8 is a configuration error, enforced by an elaboration-time check.

Decomposition:
- Shared package (arith_pkg): function clog2; constant DEF_GRP=4; a stage-record layout helper giving the sum/operand/carry field widths per stage index.
- One combinational sub-module, cla_group (parameter GRP): inputs A, B', cin; outputs S and cout. It is instantiated once per stage.
- The top level holds only the stage registers and the ready chain.

Test Plan (WIDTH=16, GRP=4, latency 4):
- 0x7FFF + 0x0001, sub=0, cin=0 -> sum 0x8000, cout 0, ovf 1, zero 0, out_valid exactly 4 cycles after accept.
- 0xFFFF + 0x0001, sub=0, cin=0 -> sum 0x0000, cout 1, ovf 0, zero 1 (carry crosses every group/stage).
- 0x0005 − 0x0007, sub=1, cin=0 -> sum 0xFFFE, cout 0, ovf 0. 0x8000 − 0x0001, sub=1 -> 0x7FFF, cout 1, ovf 1. 0x0010 − 0x0003 with cin=1 -> 0x000C.
- Back-pressure stream:
  - Stimulus: 8 back-to-back beats (A=i, B=0x0100*i), with out_ready=0 for cycles 4–9.
  - in_ready drops once 4 beats are held.
  - out_sum/flags stay stable while stalled.
  - All 8 results arrive in order with no loss or duplication.
- Random stream with random in_valid/out_ready vs a golden model (≥10k beats) -> all results match; no beat loss.
- Reset asserted with 3 beats in flight and out_ready=0 -> out_valid=0 and all outputs 0 immediately (before the next edge); after release in_ready=1 and the next beat emerges with correct value at latency 4.
